// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Four-digit BCD mm:ss countdown timer. A preset is loaded, then the value
//   counts down one second per 1 Hz tick through a mod-10/mod-6 borrow chain.
//   Reaching 00:00 pulses done and raises alarm until the user acknowledges it
//   or ALARM_TICKS ticks have elapsed.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | digits hold; load accepted; start (non-zero) -> RUN
//   RUN   | decrement on tick; pause -> PAUSE; 00:01 + tick -> ALARM
//   PAUSE | digits hold, ticks ignored; load accepted; start -> RUN
//   ALARM | digits 0000, alarm high; start/pause or ALARM_TICKS ticks -> IDLE
//
// Ports
//   clk                 system clock, rising edge
//   cr                  asynchronous active-high reset
//   tick                one-cycle 1 Hz enable
//   load, load_value    BCD preset {min_tens,min_ones,sec_tens,sec_ones}
//   start, pause        run control / alarm acknowledge
//   min_tens..sec_ones  current BCD digits
//   state               00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM
//   zero                all digits zero (combinational)
//   done                one-cycle pulse on reaching 00:00 from RUN
//   alarm               high throughout ALARM
module bcd_countdown_timer #(
  parameter int MAX_MIN_TENS = 5,
  parameter int ALARM_TICKS  = 10
) (
  input  logic        clk,
  input  logic        cr,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic [1:0]  state,
  output logic        zero,
  output logic        done,
  output logic        alarm
);

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);
  localparam int         CW     = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_sec;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  assign zero     = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign last_sec = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

  // Borrow chain: each digit wraps to its max only when it was already zero.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q - 4'd1;
    if (so_q == 4'd0) begin
      dec_so = 4'd9;
      dec_st = st_q - 4'd1;
      if (st_q == 4'd0) begin
        dec_st = 4'd5;
        dec_mo = mo_q - 4'd1;
        if (mo_q == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = mt_q - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (load) begin
          // load wins over a simultaneous start
          mt_d = clamp_digit(load_value[15:12], MT_MAX);
          mo_d = clamp_digit(load_value[11:8], 4'd9);
          st_d = clamp_digit(load_value[7:4], 4'd5);
          so_d = clamp_digit(load_value[3:0], 4'd9);
        end else if (start && (state_q == S_PAUSE || !zero)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (pause) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          if (zero) begin
            // Only reachable by starting from PAUSE at 00:00; never wrap.
            state_d = S_ALARM;
            cnt_d   = '0;
          end else begin
            mt_d = dec_mt;
            mo_d = dec_mo;
            st_d = dec_st;
            so_d = dec_so;
            if (last_sec) begin
              done_d  = 1'b1;
              state_d = S_ALARM;
              cnt_d   = '0;
            end
          end
        end
      end
      S_ALARM: begin
        if (start || pause) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge cr) begin
    if (cr) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign state    = state_q;
  assign done     = done_q;
  assign alarm    = (state_q == S_ALARM);

endmodule
